imem_fetch_arbiter: RTL and testbench
=====================================

# imem_fetch_arbiter

Shares the single-port, synchronous-read `instructionmemory` between two requesters: the CPU fetch stage, which presents byte program counters, and a debug/inspection read port, which presents raw word indices. The block translates and range-checks PCs, issues one memory access per cycle, and routes the registered read data back to its owner. Fetch has priority, and a starvation counter guarantees the debug port forward progress. It sits between the PC register and the instruction memory.

## Interface
- `DATA_WIDTH`, 32, instruction word width
- `ADDR_WIDTH`, 10, memory word-index width
- `PC_WIDTH`, 16, fetch PC width
- `IMEM_BASE`, 16'h31B0, byte address of memory word 0
- `STARVE_MAX`, 4, consecutive fetch wins over a waiting debug request before debug is forced (1..15)
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `f_req`  in  1  fetch request
- `f_pc`  in  PC_WIDTH  fetch byte address
- `f_gnt`  out  1  fetch granted this cycle (combinational)
- `f_valid`  out  1  fetch response valid (one cycle)
- `f_instr`  out  DATA_WIDTH  fetched instruction
- `f_fault`  out  1  fetch address illegal, qualified by `f_valid`
- `stall`  out  1  `f_req & ~f_gnt`
- `d_req`  in  1  debug read request
- `d_addr`  in  ADDR_WIDTH  debug word index
- `d_gnt`  out  1  debug granted this cycle (combinational)
- `d_valid`  out  1  debug response valid (one cycle)
- `d_data`  out  DATA_WIDTH  debug read data
- `mem_addr`  out  ADDR_WIDTH  to memory `address` (combinational)
- `mem_rdata`  in  DATA_WIDTH  from memory `out` (registered inside memory)

## Operation
- **PC translation:** `off = f_pc - IMEM_BASE`, computed PC_WIDTH wide. A fault is flagged when any of the following holds:
  - `f_pc < IMEM_BASE`
  - `f_pc[1:0] != 0`
  - `off[PC_WIDTH-1:2] >= 2**ADDR_WIDTH`
- **Word index:** `off[ADDR_WIDTH+1:2]`.
- **Grant:** at most one grant per cycle.
  - `d_gnt = d_req & (~f_req | cnt == STARVE_MAX)`.
  - `f_gnt = f_req & ~d_gnt`.
- **Memory address:**
  - Fetch grant: word index, or 0 if faulting.
  - Debug grant: `d_addr`.
  - No grant: 0.
- **Starvation counter `cnt`:**
  - Increments, saturating at STARVE_MAX, when `f_gnt & d_req`.
  - Clears on `d_gnt` or when `d_req` is low.
- **Response tracking:** a registered owner tag (NONE / FETCH / DEBUG) plus a registered fault bit, loaded every cycle from that cycle's grant.
- **Response routing:**
  - `f_valid = (owner == FETCH)`.
  - `f_instr = f_valid & ~fault_q ? mem_rdata : 0`. A faulting fetch returns a NOP.
  - `f_fault = f_valid & fault_q`.
  - `d_valid = (owner == DEBUG)`.
  - `d_data = d_valid ? mem_rdata : 0`.
- **No buffering:** responses last one cycle and are not held. Requesters capture them on the `valid` cycle.
- **Request changes:** requests may change every cycle. A request not granted is simply not served; the requester keeps `req` high to retry.

## Timing
- Grant and `mem_addr` are combinational in cycle N. `valid` and data appear in cycle N+1. Latency is 1.
- Throughput is one access per cycle, with back-to-back grants to either owner allowed.
- Reset values (while `rst_n` low, and immediately after assertion):
  - owner = NONE, `fault_q` = 0, `cnt` = 0.
  - `f_valid`, `d_valid`, `f_fault` = 0.
  - `f_instr`, `d_data` = 0.
  - Grants and `mem_addr` still follow the inputs combinationally.
- Reset asserted with a response pending: the pending response is discarded and no `valid` is issued after release.
- Simultaneous requests with `cnt < STARVE_MAX`: fetch wins and `stall` = 0. With `cnt == STARVE_MAX`: debug wins, `stall` = 1, and `cnt` returns to 0.
- A faulting fetch still consumes the slot and blocks debug that cycle unless debug is forced.

## Test plan
- **Fetch, legal PC:**
  - Stimulus: `f_req=1`, `f_pc=16'h31BC`, memory word 3 = 32'hBC01_22B0.
  - Required: `f_gnt=1` and `mem_addr=3` in cycle N; `f_valid=1`, `f_instr=32'hBC01_22B0`, `f_fault=0` in N+1.
- **Fetch boundaries:**
  - `f_pc=16'h41AC` → `mem_addr=1023`, no fault.
  - `16'h41B0`, `16'h31AC` and `16'h31BE` → `f_valid=1`, `f_fault=1`, `f_instr=0`, `mem_addr=0`.
- **Debug alone:**
  - Stimulus: `d_req=1`, `d_addr=7`, `f_req=0`.
  - Required: `d_gnt=1` and `mem_addr=7`; `d_valid=1` next cycle with word 7 data; `f_valid=0`.
- **Starvation, STARVE_MAX=4:**
  - Stimulus: both requests held high for 15 cycles.
  - Required grant sequence: F,F,F,F,D,F,F,F,F,D,F,F,F,F,D.
  - `stall=1` exactly on the D cycles; each `valid` is routed to the correct owner one cycle later.
- **Counter clearing:**
  - Stimulus: both requests high for 3 cycles, `d_req` low for 1 cycle, then both high.
  - Required: debug is not granted until 4 further fetch wins, showing the counter cleared.
- **Reset mid-flight:**
  - Stimulus: fetch granted in cycle N, `rst_n` low during N+1.
  - Required: `f_valid=0` and `f_instr=0` throughout. After release, a fresh request at `16'h31B0` returns word 0 with latency 1.

Source files
------------

// File: rtl/imem_fetch_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : imem_fetch_arbiter                                           |
// | Description : Shares a synchronous-read instruction memory between CPU     |
// |               fetch (byte PCs) and a debug read port, fetch priority with  |
// |               a starvation guard for debug.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module imem_fetch_arbiter #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 10,
    parameter int                  PC_WIDTH   = 16,
    parameter logic [PC_WIDTH-1:0] IMEM_BASE  = 16'h31B0,
    parameter int                  STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  f_req,
    input  logic [PC_WIDTH-1:0]   f_pc,
    output logic                  f_gnt,
    output logic                  f_valid,
    output logic [DATA_WIDTH-1:0] f_instr,
    output logic                  f_fault,
    output logic                  stall,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    output logic                  d_gnt,
    output logic                  d_valid,
    output logic [DATA_WIDTH-1:0] d_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] c_OWN_NONE  = 2'd0;
    localparam logic [1:0] c_OWN_FETCH = 2'd1;
    localparam logic [1:0] c_OWN_DEBUG = 2'd2;
    localparam logic [3:0] c_CNT_MAX   = 4'(STARVE_MAX);

    // Word part of (f_pc - IMEM_BASE); exact whenever f_pc is word aligned,
    // and misaligned PCs fault regardless of its value.
    localparam logic [PC_WIDTH-3:0] c_BASE_WORD =
        IMEM_BASE[PC_WIDTH-1:2] + {{(PC_WIDTH-3){1'b0}}, |IMEM_BASE[1:0]};

    logic [PC_WIDTH-3:0]   w_off_words;
    logic                  w_out_of_range;
    logic                  w_fault;
    logic [ADDR_WIDTH-1:0] w_widx;
    logic [3:0]            r_cnt;
    logic [1:0]            r_owner;
    logic                  r_fault;

    assign w_off_words = f_pc[PC_WIDTH-1:2] - c_BASE_WORD;

    generate
        if (PC_WIDTH - 2 > ADDR_WIDTH) begin : g_range_hi
            assign w_out_of_range = |w_off_words[PC_WIDTH-3:ADDR_WIDTH];
        end else begin : g_range_none
            assign w_out_of_range = 1'b0;
        end
    endgenerate

    assign w_fault = (f_pc < IMEM_BASE) | (f_pc[1:0] != 2'b00) | w_out_of_range;
    assign w_widx  = w_off_words[ADDR_WIDTH-1:0];

    assign d_gnt = d_req & (~f_req | (r_cnt == c_CNT_MAX));
    assign f_gnt = f_req & ~d_gnt;
    assign stall = f_req & ~f_gnt;

    always_comb begin
        mem_addr = '0;
        if (f_gnt) begin
            if (!w_fault) begin
                mem_addr = w_widx;
            end
        end else if (d_gnt) begin
            mem_addr = d_addr;
        end
    end

    // Any cycle where debug waits behind fetch counts; otherwise start over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (d_gnt || !d_req) begin
            r_cnt <= '0;
        end else if (r_cnt != c_CNT_MAX) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= c_OWN_NONE;
            r_fault <= 1'b0;
        end else begin
            r_owner <= f_gnt ? c_OWN_FETCH : (d_gnt ? c_OWN_DEBUG : c_OWN_NONE);
            r_fault <= f_gnt & w_fault;
        end
    end

    assign f_valid = (r_owner == c_OWN_FETCH);
    assign f_instr = (f_valid && !r_fault) ? mem_rdata : '0;
    assign f_fault = f_valid & r_fault;
    assign d_valid = (r_owner == c_OWN_DEBUG);
    assign d_data  = d_valid ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_imem_fetch_arbiter                                        |
// | Description : Directed self-checking bench for imem_fetch_arbiter.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_imem_fetch_arbiter;

    localparam logic [31:0] c_W0    = 32'h1357_9BDF;
    localparam logic [31:0] c_W3    = 32'hBC01_22B0;
    localparam logic [31:0] c_W7    = 32'h7777_0007;
    localparam logic [31:0] c_W1023 = 32'hFACE_03FF;

    logic        clk;
    logic        rst_n;
    logic        f_req;
    logic [15:0] f_pc;
    logic        f_gnt;
    logic        f_valid;
    logic [31:0] f_instr;
    logic        f_fault;
    logic        stall;
    logic        d_req;
    logic [9:0]  d_addr;
    logic        d_gnt;
    logic        d_valid;
    logic [31:0] d_data;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    int          checks;
    int          failures;

    imem_fetch_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .f_req     (f_req),
        .f_pc      (f_pc),
        .f_gnt     (f_gnt),
        .f_valid   (f_valid),
        .f_instr   (f_instr),
        .f_fault   (f_fault),
        .stall     (stall),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_gnt     (d_gnt),
        .d_valid   (d_valid),
        .d_data    (d_data),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory model
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive requests, check the grant side, then the response.
    task automatic step(input string tag,
                        input logic fr, input logic [15:0] pc,
                        input logic dr, input logic [9:0] da,
                        input logic efg, input logic edg, input logic [9:0] eaddr,
                        input logic efv, input logic [31:0] einst, input logic eff,
                        input logic edv, input logic [31:0] edd);
        @(negedge clk);
        f_req  = fr;
        f_pc   = pc;
        d_req  = dr;
        d_addr = da;
        #1;
        chk({tag, ".f_gnt"}, 32'(f_gnt), 32'(efg));
        chk({tag, ".d_gnt"}, 32'(d_gnt), 32'(edg));
        chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(eaddr));
        chk({tag, ".stall"}, 32'(stall), 32'(fr & ~efg));
        @(posedge clk);
        #1;
        chk({tag, ".f_valid"}, 32'(f_valid), 32'(efv));
        chk({tag, ".f_instr"}, f_instr, einst);
        chk({tag, ".f_fault"}, 32'(f_fault), 32'(eff));
        chk({tag, ".d_valid"}, 32'(d_valid), 32'(edv));
        chk({tag, ".d_data"}, d_data, edd);
    endtask

    initial begin
        logic isd;
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[0]    = c_W0;
        mem[3]    = c_W3;
        mem[7]    = c_W7;
        mem[1023] = c_W1023;
        rst_n  = 1'b0;
        f_req  = 1'b0;
        f_pc   = 16'h0000;
        d_req  = 1'b0;
        d_addr = 10'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.f_valid", 32'(f_valid), 32'd0);
        chk("rst.d_valid", 32'(d_valid), 32'd0);
        chk("rst.f_fault", 32'(f_fault), 32'd0);
        chk("rst.f_instr", f_instr, 32'd0);
        chk("rst.d_data", d_data, 32'd0);
        f_req = 1'b1;
        f_pc  = 16'h31BC;
        #1;
        chk("rst.comb_f_gnt", 32'(f_gnt), 32'd1);
        chk("rst.comb_mem_addr", 32'(mem_addr), 32'd3);
        @(posedge clk);
        #1;
        chk("rst.held_f_valid", 32'(f_valid), 32'd0);
        @(negedge clk);
        f_req = 1'b0;
        rst_n = 1'b1;

        // Fetch, legal and boundary PCs
        step("fetch_legal", 1, 16'h31BC, 0, 10'd0, 1, 0, 10'd3,    1, c_W3,    0, 0, 32'd0);
        step("fetch_top",   1, 16'h41AC, 0, 10'd0, 1, 0, 10'd1023, 1, c_W1023, 0, 0, 32'd0);
        step("fetch_over",  1, 16'h41B0, 0, 10'd0, 1, 0, 10'd0,    1, 32'd0,   1, 0, 32'd0);
        step("fetch_under", 1, 16'h31AC, 0, 10'd0, 1, 0, 10'd0,    1, 32'd0,   1, 0, 32'd0);
        step("fetch_misal", 1, 16'h31BE, 0, 10'd0, 1, 0, 10'd0,    1, 32'd0,   1, 0, 32'd0);
        step("fetch_base",  1, 16'h31B0, 0, 10'd0, 1, 0, 10'd0,    1, c_W0,    0, 0, 32'd0);

        // Debug alone, then a faulting fetch still blocking debug
        step("dbg_alone",   0, 16'h0000, 1, 10'd7, 0, 1, 10'd7,    0, 32'd0,   0, 1, c_W7);
        step("fault_blk",   1, 16'h31AC, 1, 10'd7, 1, 0, 10'd0,    1, 32'd0,   1, 0, 32'd0);
        step("idle",        0, 16'h0000, 0, 10'd0, 0, 0, 10'd0,    0, 32'd0,   0, 0, 32'd0);

        // Starvation: F,F,F,F,D repeating
        for (int i = 0; i < 15; i++) begin
            isd = ((i % 5) == 4);
            step($sformatf("starve%0d", i), 1, 16'h31BC, 1, 10'd7,
                 !isd, isd, isd ? 10'd7 : 10'd3,
                 !isd, isd ? 32'd0 : c_W3, 0,
                 isd, isd ? c_W7 : 32'd0);
        end

        // Counter clearing: 3 fetch wins, debug drops, then 4 more before debug
        for (int i = 0; i < 3; i++)
            step($sformatf("clr_pre%0d", i), 1, 16'h31BC, 1, 10'd7, 1, 0, 10'd3, 1, c_W3, 0, 0, 32'd0);
        step("clr_drop", 1, 16'h31BC, 0, 10'd7, 1, 0, 10'd3, 1, c_W3, 0, 0, 32'd0);
        for (int i = 0; i < 4; i++)
            step($sformatf("clr_post%0d", i), 1, 16'h31BC, 1, 10'd7, 1, 0, 10'd3, 1, c_W3, 0, 0, 32'd0);
        step("clr_dbg", 1, 16'h31BC, 1, 10'd7, 0, 1, 10'd7, 0, 32'd0, 0, 1, c_W7);

        // Reset while a fetch response is pending
        @(negedge clk);
        f_req = 1'b1;
        f_pc  = 16'h31BC;
        d_req = 1'b0;
        #1;
        chk("rstmid.f_gnt", 32'(f_gnt), 32'd1);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rstmid.f_valid", 32'(f_valid), 32'd0);
        chk("rstmid.f_instr", f_instr, 32'd0);
        @(negedge clk);
        f_req = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid.after_f_valid", 32'(f_valid), 32'd0);
        chk("rstmid.after_f_instr", f_instr, 32'd0);
        step("rst_fresh", 1, 16'h31B0, 0, 10'd0, 1, 0, 10'd0, 1, c_W0, 0, 0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
